// File: rtl/apb_pkg.sv
// Shared types and helpers for the parametrised APB4 memory slave.
// Holds the transfer FSM states, the response encoding and the address-window check.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    // Widened to 32 bits so one helper serves every ADDR_W / MEM_DEPTH combination.
    function automatic logic addr_valid(
        input logic [31:0] addr,
        input logic [31:0] lo,
        input logic [31:0] hi,
        input logic [31:0] depth
    );
        return (addr >= lo) && (addr <= hi) && (addr < depth);
    endfunction

endpackage

// File: rtl/apb_bytemem.sv
// Flop-based word memory with per-byte write enables and a combinational read port.
// Every word clears on reset so software always reads a known value after power-up.
module apb_bytemem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_waddr,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [IDX_W-1:0]    i_raddr,
    output logic [DATA_W-1:0]   o_rdata
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the array is reset word by word; this forbids RAM-macro inference,
    // which is acceptable because the memory is defined as flops cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            // NOTE: non-blocking assignments keep every flop update ordered after all reads of this edge.
            for (int k = 0; k < STRB_W; k++) begin
                if (i_wstrb[k]) begin
                    r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_mem_slave_p.sv
// APB4 slave in front of a byte-writable scratch memory with an address window,
// fixed wait states and protocol-violation detection that aborts but never locks up.
module apb_mem_slave_p
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 32,
    parameter int                MEM_DEPTH   = 256,
    parameter logic [ADDR_W-1:0] ADDR_LO     = 'h05,
    parameter logic [ADDR_W-1:0] ADDR_HI     = 'hF1,
    parameter int                WAIT_CYCLES = 0
) (
    input  logic                PCLK,
    input  logic                RSTN,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic                prot_err
);

    localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_wcnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic                r_valid;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_prot_err;

    logic                w_in_valid;
    logic                w_setup;
    logic                w_violation;
    logic                w_pready;
    logic                w_load;
    logic                w_dec;
    logic                w_complete;
    logic                w_prot;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_mem_rdata;

    assign w_in_valid = addr_valid(32'(PADDR), 32'(ADDR_LO), 32'(ADDR_HI), 32'(MEM_DEPTH));
    assign w_setup    = PSEL && !PENABLE;
    assign w_pready   = (r_state == ACCESS) && (r_wcnt == 4'd0);

    // Any break in the held PSEL/PENABLE/PADDR/PWRITE pattern aborts the access.
    assign w_violation = !PSEL || !PENABLE || (PADDR != r_addr) || (PWRITE != r_write);

    always_ff @(posedge PCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_complete   = 1'b0;
        w_prot       = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSEL && PENABLE) begin
                    w_prot = 1'b1;
                end else if (PSEL) begin
                    w_load       = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (w_violation) begin
                    w_prot = 1'b1;
                    if (w_setup) begin
                        w_load       = 1'b1;
                        w_next_state = ACCESS;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (r_wcnt != 4'd0) begin
                    w_dec = 1'b1;
                end else begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wcnt     <= 4'd0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_valid    <= 1'b0;
            r_prdata   <= '0;
            r_prot_err <= 1'b0;
        end else begin
            r_prot_err <= w_prot;
            if (w_load) begin
                r_wcnt  <= WAIT_INIT;
                r_addr  <= PADDR;
                r_write <= PWRITE;
                r_valid <= w_in_valid;
                // Read data is fetched at setup so PRDATA is stable for the whole access phase.
                if (!PWRITE) begin
                    r_prdata <= w_in_valid ? w_mem_rdata : '0;
                end
            end else if (w_dec) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
        end
    end

    assign w_mem_we = w_complete && r_write && r_valid;

    apb_bytemem #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (PCLK),
        .rst_n   (RSTN),
        .i_we    (w_mem_we),
        .i_waddr (r_addr[IDX_W-1:0]),
        .i_wstrb (PSTRB),
        .i_wdata (PWDATA),
        .i_raddr (PADDR[IDX_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    assign PRDATA   = r_prdata;
    assign PREADY   = w_pready;
    assign PSLVERR  = (w_pready && !r_valid) ? RESP_SLVERR : RESP_OKAY;
    assign prot_err = r_prot_err;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Directed bench for apb_mem_slave_p: three instances (2, 0 and 3 wait states) on one clock,
// expected responses queued at setup and checked when PREADY is observed.
module tb_apb_mem_slave_p;

    localparam int NDUT = 3;
    localparam int WAITS [NDUT] = '{2, 0, 3};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        PCLK;
    logic        RSTN;
    logic        psel    [NDUT];
    logic        penable [NDUT];
    logic        pwrite  [NDUT];
    logic [7:0]  paddr   [NDUT];
    logic [31:0] pwdata  [NDUT];
    logic [3:0]  pstrb   [NDUT];
    logic [31:0] prdata  [NDUT];
    logic        pready  [NDUT];
    logic        pslverr [NDUT];
    logic        prot_err[NDUT];

    logic [31:0] last_rd [NDUT];
    int          prot_cnt[NDUT];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb_mem_slave_p #(
            .ADDR_W      (8),
            .DATA_W      (32),
            .MEM_DEPTH   (256),
            .ADDR_LO     (8'h05),
            .ADDR_HI     (8'hF1),
            .WAIT_CYCLES (WAITS[g])
        ) u_dut (
            .PCLK     (PCLK),
            .RSTN     (RSTN),
            .PSEL     (psel[g]),
            .PENABLE  (penable[g]),
            .PWRITE   (pwrite[g]),
            .PADDR    (paddr[g]),
            .PWDATA   (pwdata[g]),
            .PSTRB    (pstrb[g]),
            .PRDATA   (prdata[g]),
            .PREADY   (pready[g]),
            .PSLVERR  (pslverr[g]),
            .prot_err (prot_err[g])
        );
    end

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        for (int i = 0; i < NDUT; i++) begin
            if (prot_err[i] === 1'b1) prot_cnt[i]++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic go_idle(input int d);
        @(negedge PCLK);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge PCLK);
    endtask

    // Leaves PSEL/PENABLE high on return so a following call forms a back-to-back transfer.
    task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   cyc;
        string tag;
        tag = $sformatf("d%0d %s @%h", d, wr ? "wr" : "rd", a);
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = WAITS[d] + 1;
        sb.push_back(e);
        @(negedge PCLK);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
        @(negedge PCLK);
        penable[d] = 1'b1;
        cyc = 1;
        while (pready[d] !== 1'b1 && cyc < 20) begin
            @(negedge PCLK);
            cyc++;
        end
        e = sb.pop_front();
        if (pready[d] !== 1'b1) begin
            check({tag, " timeout"}, {31'd0, pready[d]}, 32'd1);
        end else begin
            check({tag, " latency"}, 32'(cyc), 32'(e.lat));
            check({tag, " pslverr"}, {31'd0, pslverr[d]}, {31'd0, e.err});
            check({tag, " prdata"}, prdata[d], e.rdata);
        end
    endtask

    task automatic wr(input int d, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic exp_err);
        xfer(d, 1'b1, a, wd, st, last_rd[d], exp_err);
    endtask

    task automatic rd(input int d, input logic [7:0] a, input logic [31:0] exp, input logic exp_err);
        xfer(d, 1'b0, a, 32'hFFFF_FFFF, 4'hF, exp, exp_err);
        last_rd[d] = exp;
    endtask

    initial begin
        int p0;
        logic [7:0] rst_addrs [5];
        rst_addrs = '{8'hCA, 8'h37, 8'hB1, 8'h30, 8'h40};
        RSTN = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
            last_rd[i] = '0; prot_cnt[i] = 0;
        end
        #12;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("d%0d reset pready", i), {31'd0, pready[i]}, 32'd0);
            check($sformatf("d%0d reset pslverr", i), {31'd0, pslverr[i]}, 32'd0);
            check($sformatf("d%0d reset prdata", i), prdata[i], 32'd0);
            check($sformatf("d%0d reset prot_err", i), {31'd0, prot_err[i]}, 32'd0);
        end
        @(negedge PCLK);
        RSTN = 1'b1;

        // Basic write/read with 2 and 0 wait states.
        wr(0, 8'hCA, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd(0, 8'hCA, 32'hDEAD_BEEF, 1'b0);
        go_idle(0);
        wr(1, 8'hCA, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd(1, 8'hCA, 32'hDEAD_BEEF, 1'b0);
        go_idle(1);

        // Byte strobes, including an all-zero strobe that must leave the word alone.
        wr(0, 8'h37, 32'h1122_3344, 4'hF, 1'b0);
        wr(0, 8'h37, 32'hAABB_CCDD, 4'b0101, 1'b0);
        rd(0, 8'h37, 32'h11BB_33DD, 1'b0);
        wr(0, 8'h37, 32'h0000_0000, 4'b0000, 1'b0);
        rd(0, 8'h37, 32'h11BB_33DD, 1'b0);

        // Address window and its edges.
        wr(0, 8'hFF, 32'h1234_5678, 4'hF, 1'b1);
        rd(0, 8'hFF, 32'h0, 1'b1);
        rd(0, 8'h01, 32'h0, 1'b1);
        wr(0, 8'hB1, 32'h0000_000F, 4'hF, 1'b0);
        rd(0, 8'hB1, 32'h0000_000F, 1'b0);
        rd(0, 8'h04, 32'h0, 1'b1);
        rd(0, 8'h05, 32'h0, 1'b0);
        rd(0, 8'hF1, 32'h0, 1'b0);
        rd(0, 8'hF2, 32'h0, 1'b1);
        go_idle(0);

        // Access phase without setup.
        p0 = prot_cnt[0];
        @(negedge PCLK);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 8'hCA; pwdata[0] = 32'h5555_5555; pstrb[0] = 4'hF;
        @(negedge PCLK);
        check("no-setup pready", {31'd0, pready[0]}, 32'd0);
        check("no-setup prot_err", {31'd0, prot_err[0]}, 32'd1);
        psel[0] = 1'b0; penable[0] = 1'b0;
        wait_neg(3);
        check("no-setup pulse count", 32'(prot_cnt[0] - p0), 32'd1);
        rd(0, 8'hCA, 32'hDEAD_BEEF, 1'b0);
        go_idle(0);

        // PENABLE held after completion with a new address and data.
        wr(0, 8'h30, 32'h0000_1234, 4'hF, 1'b0);
        p0 = prot_cnt[0];
        @(negedge PCLK);
        paddr[0] = 8'h21; pwdata[0] = 32'h0000_00CD;
        @(negedge PCLK);
        psel[0] = 1'b0; penable[0] = 1'b0;
        wait_neg(3);
        check("held-penable pulse count", 32'(prot_cnt[0] - p0), 32'd1);
        rd(0, 8'h21, 32'h0, 1'b0);
        rd(0, 8'h30, 32'h0000_1234, 1'b0);
        go_idle(0);

        // Aborts during wait states (3 wait states).
        p0 = prot_cnt[2];
        @(negedge PCLK);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 8'h40; pwdata[2] = 32'h0000_0099; pstrb[2] = 4'hF;
        @(negedge PCLK);
        penable[2] = 1'b1;
        @(negedge PCLK);
        check("drop-psel pready in wait", {31'd0, pready[2]}, 32'd0);
        psel[2] = 1'b0; penable[2] = 1'b0;
        wait_neg(3);
        check("drop-psel pulse count", 32'(prot_cnt[2] - p0), 32'd1);
        rd(2, 8'h40, 32'h0, 1'b0);
        go_idle(2);

        p0 = prot_cnt[2];
        @(negedge PCLK);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 8'h20; pwdata[2] = 32'h0000_00AB; pstrb[2] = 4'hF;
        @(negedge PCLK);
        penable[2] = 1'b1;
        @(negedge PCLK);
        paddr[2] = 8'h21;
        @(negedge PCLK);
        psel[2] = 1'b0; penable[2] = 1'b0;
        wait_neg(3);
        check("addr-change pulse count", 32'(prot_cnt[2] - p0), 32'd1);
        rd(2, 8'h20, 32'h0, 1'b0);
        rd(2, 8'h21, 32'h0, 1'b0);
        wr(2, 8'h40, 32'h0000_0099, 4'hF, 1'b0);
        rd(2, 8'h40, 32'h0000_0099, 1'b0);
        go_idle(2);

        // Reset while an errored write is completing; PRDATA still holds the last read.
        @(negedge PCLK);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'hFF; pwdata[1] = 32'h0; pstrb[1] = 4'hF;
        @(negedge PCLK);
        penable[1] = 1'b1;
        check("pre-reset pready", {31'd0, pready[1]}, 32'd1);
        check("pre-reset pslverr", {31'd0, pslverr[1]}, 32'd1);
        check("pre-reset prdata", prdata[1], 32'hDEAD_BEEF);
        #2 RSTN = 1'b0;
        #1;
        check("in-reset pready", {31'd0, pready[1]}, 32'd0);
        check("in-reset pslverr", {31'd0, pslverr[1]}, 32'd0);
        check("in-reset prdata", prdata[1], 32'd0);
        check("in-reset prdata d0", prdata[0], 32'd0);
        @(negedge PCLK);
        for (int i = 0; i < NDUT; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0;
            last_rd[i] = '0;
        end
        RSTN = 1'b1;

        for (int i = 0; i < NDUT; i++) begin
            for (int j = 0; j < 5; j++) begin
                rd(i, rst_addrs[j], 32'h0, 1'b0);
            end
            go_idle(i);
        end
        wr(1, 8'hCA, 32'h5A5A_5A5A, 4'hF, 1'b0);
        rd(1, 8'hCA, 32'h5A5A_5A5A, 1'b0);
        go_idle(1);
        wait_neg(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave_p.md
Name: apb_mem_slave_p

Overview:
- Parametrised APB4 memory-mapped slave; next generation of the team's 8-bit APB slave.
- Adds configurable data/address width, memory depth, valid-address window, fixed wait states and PSTRB byte-lane writes.
- Detects protocol violations, aborts the transfer and pulses a flag, but does not lock out later transfers.
- Sits behind the APB bridge/master as a generic register or scratch memory.

Parameters:
- ADDR_W, 8, PADDR width; word-addressed, so PADDR indexes the word directly.
- DATA_W, 32, PWDATA/PRDATA width; must be a multiple of 8.
- MEM_DEPTH, 256, number of words; must be <= 2**ADDR_W.
- ADDR_LO, 8'h05, lowest valid word address.
- ADDR_HI, 8'hF1, highest valid word address; must be < MEM_DEPTH.
- WAIT_CYCLES, 0, wait states inserted in ACCESS before PREADY; range 0..15.

Ports:
- PCLK  in  1  clock.
- RSTN  in  1  reset; asynchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_W  word address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  write byte strobes; ignored on reads.
- PRDATA  out  DATA_W  read data.
- PREADY  out  1  transfer completes in this cycle.
- PSLVERR  out  1  error response; meaningful only while PREADY=1.
- prot_err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset (RSTN low, async):
  - State goes to IDLE, wait counter to 0.
  - PREADY=0, PSLVERR=0, PRDATA=0, prot_err=0.
  - All memory words are cleared to 0; memory is flop-based.
- Address validity: valid = (ADDR_LO <= PADDR <= ADDR_HI) && (PADDR < MEM_DEPTH).
- FSM has two states, IDLE and ACCESS. All transitions occur on the PCLK rising edge.
- IDLE:
  - PSEL=1, PENABLE=0 (setup) → ACCESS.
    - Latch PADDR, PWRITE and the valid bit.
    - Load wait counter with WAIT_CYCLES.
    - On a valid read, load PRDATA with mem[PADDR]; on an invalid read, load PRDATA with 0.
  - PSEL=1, PENABLE=1 (no setup phase) → prot_err pulses for 1 cycle; stay IDLE; no access.
  - PSEL=0 → stay IDLE.
- ACCESS:
  - PREADY = (state==ACCESS) && (wcnt==0); combinational.
  - PSLVERR = PREADY && !latched_valid.
  - Violation: PSEL=0, PENABLE=0, or PADDR/PWRITE differ from the latched values.
    - prot_err pulses; transfer is aborted; no memory write.
    - Next state is IDLE, except PSEL=1 with PENABLE=0, which is treated as a new setup → ACCESS with a fresh latch.
  - wcnt>0 with no violation → decrement wcnt.
  - wcnt==0 with no violation → transfer completes → IDLE.
    - Valid write: for each k with PSTRB[k]=1, mem[a][8k+7:8k] <= PWDATA[8k+7:8k].
    - PSTRB=0 on a write: completes with no change and no error.
    - Invalid write: no memory change; PSLVERR=1.
- Latency: ACCESS lasts exactly WAIT_CYCLES+1 cycles; with WAIT_CYCLES=0, PREADY is high in the first ACCESS cycle.
- PRDATA:
  - Holds its value outside read-completion cycles.
  - After a write, holds the last read value.
- Back-to-back transfers: after completion, the master's next setup is seen in IDLE; no dead cycle is required.
- PENABLE held high after completion (burst without setup): handled by the IDLE rule, so prot_err pulses and no write occurs.
- A violation or slave error never blocks subsequent transfers; there is no sticky state.

Decomposition:
- Package apb_pkg:
  - State enum (IDLE, ACCESS).
  - Response constants (OKAY=0, SLVERR=1).
  - Function addr_valid(addr, lo, hi, depth).
- One sub-module, apb_bytemem:
  - MEM_DEPTH x DATA_W flop array with async reset clear.
  - Byte-enable write port and combinational read port.
- FSM, wait counter and APB outputs stay in apb_mem_slave_p.

Test Plan:
- Basic write/read (DATA_W=32, WAIT_CYCLES=2): write 0xCA=0xDEADBEEF with PSTRB=4'hF, then read 0xCA → PREADY in the 3rd ACCESS cycle of each transfer; PRDATA=0xDEADBEEF; PSLVERR=0. Rerun with WAIT_CYCLES=0 → PREADY in the 1st ACCESS cycle.
- Byte strobes: write 0x37=0x11223344 with PSTRB=4'hF, then 0xAABBCCDD with PSTRB=4'b0101 → read 0x37 returns 0x11BB33DD.
- Invalid address: write 0xFF=0x12345678, then read 0xFF and read 0x01 → each completes with PSLVERR=1 and PRDATA=0, memory unchanged. A following valid write to 0xB1=0x0F then read → PSLVERR=0, PRDATA=0x0F.
- Protocol violations:
  - PSEL=1, PENABLE=1 in IDLE with write to 0xCA → one prot_err pulse; PREADY stays 0; mem[0xCA] unchanged.
  - PENABLE held high after completion, with PADDR/PWDATA changed to 0x21/0xCD → one prot_err pulse; no write to 0x21.
- Abort (WAIT_CYCLES=3): drop PSEL during a wait cycle → prot_err; no write. Change PADDR 0x20→0x21 mid-ACCESS → prot_err; neither address written.
- Reset mid-ACCESS: deassert RSTN between edges → PREADY, PSLVERR and PRDATA go to 0 immediately; all memory words read 0 after RSTN=1; the next transfer behaves normally.
